// File: rtl/dmem_responder.sv
// Data-memory responder for the M stage: wait-stated word array with stall/done/err handshake.
// Optional byte-lane stores are enabled by defining DMEM_BYTE_EN_EN.
module dmem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
`ifdef DMEM_BYTE_EN_EN
  input  logic [3:0]  byte_en,
`endif
  output logic [31:0] read_data,
  output logic        stall,
  output logic        done,
  output logic        err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t          state_r;
  logic [CW-1:0]   cnt_r;
  logic [AW-1:0]   wordIdx_r;
  logic [31:0]     wdata_r;
  logic            isWrite_r;
  logic            fault_r;
  logic [31:0]     rdata_r;
`ifdef DMEM_BYTE_EN_EN
  logic [3:0]      be_r;
`endif
  logic [31:0]     mem [DEPTH];

  logic            req_s;
  logic            fault_s;
  logic            execute_s;
  logic            execStore_s;
  logic [3:0]      laneEn_s;

  // Request decode and fault classification of the incoming access
  always_comb begin
    req_s   = mem_read | mem_write;
    fault_s = (addr[1:0] != 2'b00) | (|addr[31:AW+2]) | (mem_read & mem_write);
    execute_s   = (state_r == BUSY) && (cnt_r == {CW{1'b0}});
    execStore_s = execute_s && isWrite_r && !fault_r && !reset;
`ifdef DMEM_BYTE_EN_EN
    laneEn_s = be_r;
`else
    laneEn_s = 4'b1111;
`endif
  end

  // Access FSM: accept, wait-state countdown, registered load result
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      cnt_r     <= {CW{1'b0}};
      wordIdx_r <= {AW{1'b0}};
      wdata_r   <= 32'h0000_0000;
      isWrite_r <= 1'b0;
      fault_r   <= 1'b0;
      rdata_r   <= 32'h0000_0000;
`ifdef DMEM_BYTE_EN_EN
      be_r      <= 4'b0000;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (req_s) begin
            wordIdx_r <= addr[AW+1:2];
            wdata_r   <= write_data;
            isWrite_r <= mem_write;
            fault_r   <= fault_s;
`ifdef DMEM_BYTE_EN_EN
            be_r      <= byte_en;
`endif
            cnt_r     <= CNT_INIT;
            state_r   <= BUSY;
          end else begin
            state_r   <= IDLE;
          end
        end
        BUSY: begin
          if (cnt_r != {CW{1'b0}}) begin
            cnt_r <= cnt_r - CW'(1);
          end else begin
            // Faulted accesses return zero; stores leave the load result untouched
            if (fault_r) begin
              rdata_r <= 32'h0000_0000;
            end else if (!isWrite_r) begin
              rdata_r <= mem[wordIdx_r];
            end else begin
              rdata_r <= rdata_r;
            end
            state_r <= DONE;
          end
        end
        DONE:    state_r <= IDLE;
        default: state_r <= IDLE;
      endcase
    end
  end

  // Array write port, lane-masked; suppressed on the reset edge
  always_ff @(posedge clk) begin
    if (execStore_s) begin
      for (int i = 0; i < 4; i++) begin
        if (laneEn_s[i]) begin
          mem[wordIdx_r][8*i +: 8] <= wdata_r[8*i +: 8];
        end
      end
    end
  end

  // Handshake outputs decoded from the state register
  always_comb begin
    read_data = rdata_r;
    stall     = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    case (state_r)
      IDLE:    stall = req_s;
      BUSY:    stall = 1'b1;
      DONE: begin
        done = 1'b1;
        err  = fault_r;
      end
      default: stall = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus randomized accesses
// checked against a word-array reference model.
module tb_dmem_responder;

  localparam int DEPTH = 256;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read, mem_write;
  logic [31:0] addr, write_data;
  logic [31:0] read_data;
  logic        stall, done, err;
`ifdef DMEM_BYTE_EN_EN
  logic [3:0]  byte_en;
`endif

  int passed = 0;
  int total  = 0;

  logic [31:0] model [DEPTH];
  logic [31:0] lastRd;

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .mem_read(mem_read), .mem_write(mem_write),
    .addr(addr), .write_data(write_data),
`ifdef DMEM_BYTE_EN_EN
    .byte_en(byte_en),
`endif
    .read_data(read_data), .stall(stall), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One complete access starting at a negedge; returns at the negedge of the following IDLE cycle
  task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] be);
    logic        expFault;
    logic [31:0] merged;
    int          stallCycles, doneCycle, idx;
    expFault = (a[1:0] != 2'b00) || (a >= DEPTH * 4) || (rd && wr);
    idx = int'(a[31:2]) % DEPTH;
    mem_read = rd; mem_write = wr; addr = a; write_data = wd;
`ifdef DMEM_BYTE_EN_EN
    byte_en = be;
`endif
    stallCycles = 0;
    doneCycle   = -1;
    for (int c = 0; c < LAT + 8 && doneCycle < 0; c++) begin
      #1;
      if (done) doneCycle = c;
      else begin
        if (stall) stallCycles++;
        @(negedge clk);
      end
    end
    check("done_seen", 32'(doneCycle >= 0), 32'd1);
    if (doneCycle >= 0) begin
      if (expFault) lastRd = 32'h0;
      else if (wr) begin
        merged = model[idx];
`ifdef DMEM_BYTE_EN_EN
        for (int i = 0; i < 4; i++) if (be[i]) merged[8*i +: 8] = wd[8*i +: 8];
`else
        merged = wd;
`endif
        model[idx] = merged;
      end else lastRd = model[idx];
      check("done_cycle", 32'(doneCycle), 32'(LAT + 1));
      check("stall_cycles", 32'(stallCycles), 32'(LAT + 1));
      check("stall_in_done", 32'(stall), 32'd0);
      check("err", 32'(err), 32'(expFault));
      check("read_data", read_data, lastRd);
    end
    mem_read = 1'b0; mem_write = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] a;
    int kind, expDone;
    reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0; addr = 32'h0; write_data = 32'h0;
`ifdef DMEM_BYTE_EN_EN
    byte_en = 4'b1111;
`endif
    lastRd = 32'h0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_rdata", read_data, 32'h0);
    @(negedge clk);

    // Preload every word so later loads have defined contents
    for (int w = 0; w < DEPTH; w++) begin
      model[w] = 32'h0;
      access(1'b0, 1'b1, 32'(w * 4), $urandom, 4'b1111);
    end

    // Store then load back
    access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'b1111);
    access(1'b1, 1'b0, 32'h10, 32'h0, 4'b1111);
    check("t1_load", lastRd, 32'hDEADBEEF);

    // Misaligned load faults, data unaffected
    access(1'b1, 1'b0, 32'h13, 32'h0, 4'b1111);
    access(1'b1, 1'b0, 32'h10, 32'h0, 4'b1111);

    // Out-of-range store aliases word 0 but must not write it
    access(1'b0, 1'b1, 32'(DEPTH * 4), 32'hCAFEF00D, 4'b1111);
    access(1'b1, 1'b0, 32'h0, 32'h0, 4'b1111);

    // Simultaneous read and write faults without storing
    access(1'b1, 1'b1, 32'h30, 32'h55AA55AA, 4'b1111);
    access(1'b1, 1'b0, 32'h30, 32'h0, 4'b1111);

    // Reset during the second BUSY cycle discards the store
    mem_write = 1'b1; addr = 32'h20; write_data = 32'h12345678;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1; mem_write = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("t4_stall", 32'(stall), 32'd0);
    check("t4_done", 32'(done), 32'd0);
    check("t4_rdata", read_data, 32'h0);
    lastRd = 32'h0;
    @(negedge clk);
    access(1'b1, 1'b0, 32'h20, 32'h0, 4'b1111);

    // Continuous load request: one done every LAT+2 cycles
    mem_read = 1'b1; addr = 32'h10;
    for (int c = 0; c < 3 * (LAT + 2); c++) begin
      #1;
      expDone = ((c % (LAT + 2)) == LAT + 1) ? 1 : 0;
      check("t5_done", 32'(done), 32'(expDone));
      check("t5_stall", 32'(stall), 32'(1 - expDone));
      if (expDone == 1) check("t5_rdata", read_data, model[4]);
      @(negedge clk);
    end
    mem_read = 1'b0;
    lastRd = model[4];
    @(negedge clk);

`ifdef DMEM_BYTE_EN_EN
    access(1'b0, 1'b1, 32'h40, 32'hAABBCCDD, 4'b1111);
    access(1'b0, 1'b1, 32'h40, 32'h11223344, 4'b0011);
    access(1'b1, 1'b0, 32'h40, 32'h0, 4'b0000);
    check("t6_lanes", lastRd, 32'hAABB3344);
    access(1'b0, 1'b1, 32'h40, 32'h99999999, 4'b0000);
    access(1'b1, 1'b0, 32'h40, 32'h0, 4'b1010);
    check("t6_zero_be", lastRd, 32'hAABB3344);
`endif

    // Randomized mix of loads, stores and faulting accesses
    for (int n = 0; n < 80; n++) begin
      kind = $urandom_range(0, 9);
      a = 32'($urandom_range(0, DEPTH - 1)) << 2;
      case (kind)
        0:       access(1'b1, 1'b0, a | 32'($urandom_range(1, 3)), 32'h0, 4'($urandom));
        1:       access(1'b0, 1'b1, 32'(DEPTH * 4) + (a << 4), $urandom, 4'($urandom));
        2:       access(1'b1, 1'b1, a, $urandom, 4'($urandom));
        3, 4, 5: access(1'b0, 1'b1, a, $urandom, 4'($urandom));
        default: access(1'b1, 1'b0, a, 32'h0, 4'($urandom));
      endcase
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-memory responder for the pipelined core's Memory stage. It accepts load/store requests (address = ALUResultM, data = WriteDataM) and stores words in an internal array. It adds a configurable number of wait states and raises a stall request to the hazard unit until each access completes. Load data is returned for the core's ReadData input, timed so the M/W pipeline register captures it on the completion edge.

Parameters:
DEPTH, 256, number of 32-bit words in the array; power of two, minimum 4
LATENCY, 2, wait-state cycles spent in BUSY per access; minimum 1

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
mem_read  input  1  load request from the M stage
mem_write  input  1  store request from the M stage
addr  input  32  byte address (ALUResultM)
write_data  input  32  store data (WriteDataM)
read_data  output  32  load data; valid while done=1
stall  output  1  stall request to the hazard unit (freezes the F/D/E/M stages)
done  output  1  one-cycle pulse when an access completes
err  output  1  one-cycle pulse with done when the access faulted

Behaviour:
- Reset: one clock, synchronous and active-high. The ports are named clk and reset.
  - When reset=1 at an edge: state goes to IDLE, counter to 0, and the latched request regs to 0.
  - read_data=0, stall=0, done=0, err=0.
  - Array contents are not cleared.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - req = mem_read | mem_write.
  - stall = req, combinational, asserted in the same cycle the request appears.
  - On an edge with req=1: latch addr, write_data, is_write = mem_write, and fault; set cnt = LATENCY-1; go to BUSY.
- BUSY:
  - stall=1.
  - When cnt!=0: cnt decrements each edge.
  - At the edge with cnt==0, the access executes, then the FSM goes to DONE:
    - Store: array[word] <= write_data.
    - Load: rdata_q <= array[word].
    - Fault: no array change, rdata_q <= 0.
- DONE:
  - stall=0, done=1, err=fault, read_data=rdata_q.
  - mem_read/mem_write are ignored here, because the same M-stage instruction is still presented.
  - The next edge always returns to IDLE.
- read_data holds its last value outside DONE; consumers sample it only when done=1.
- Request timeline: stall is high for LATENCY+1 cycles (the IDLE accept cycle plus LATENCY BUSY cycles). done is asserted in cycle LATENCY+1, counting the accept cycle as 0.
- Word index = addr[log2(DEPTH)+1:2].
- Fault when any of these holds:
  - addr[1:0]!=0 (misaligned);
  - addr >= DEPTH*4 (out of range);
  - mem_read and mem_write both 1 (the access is treated as a store and the store is suppressed).
- Reset mid-operation: a pending store in BUSY is discarded and the array is unchanged; a pending load is dropped.
- Array read is registered only; no combinational read path from addr to read_data.

Optional Feature:
DMEM_BYTE_EN_EN.
- Defined: adds input port byte_en[3:0], latched on accept.
  - On a store, only lanes with byte_en[i]=1 are written (bits 8i+7:8i).
  - byte_en=0000 on a store leaves the word unchanged and is not a fault.
  - Loads return the full word regardless of byte_en.
- Undefined: no byte_en port; every store writes all 32 bits.

Test Plan:
1. LATENCY=2: after reset, store 0xDEADBEEF to addr 0x10 -> stall=1 in cycles 0-2, done=1 and err=0 in cycle 3, stall=0 in cycle 3. Then load 0x10 -> read_data=0xDEADBEEF while done=1.
2. Load at addr 0x13 (misaligned) -> done=1, err=1, read_data=0. Loading 0x10 afterwards still returns 0xDEADBEEF.
3. Store to addr DEPTH*4 (0x400 with DEPTH=256) -> err=1 with done. No word in the array changes; check index 0 after the store.
4. Store 0x12345678 to 0x20, with reset pulsed for one cycle during the second BUSY cycle -> stall=0, done=0 the cycle after reset. A following load of 0x20 returns the previous contents (0 or the preloaded value).
5. Hold mem_read=1 at 0x10 continuously -> exactly one done per LATENCY+2 cycles. The DONE cycle does not re-accept; the next accept occurs in the IDLE cycle after DONE.
6. With DMEM_BYTE_EN_EN defined: store 0xAABBCCDD (byte_en=1111), then store 0x11223344 with byte_en=0011 to the same address -> load returns 0xAABB3344.
